// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: PC, single-outstanding IM handshake,
// redirect merge, stale-response drop and a one-entry skid for IF/ID.
module fetch_sequencer #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hazard_stall,
  input  logic          trap_valid,
  input  logic [AW-1:0] trap_target,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_target,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_gnt,
  input  logic          im_rvalid,
  input  logic [DW-1:0] im_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_inst,
  output logic          flush
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    HOLD,
    DROP
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, pc4;
  logic [AW-1:0] tgt;
  logic          redir;
  logic [AW-1:0] skid_pc;
  logic [DW-1:0] skid_inst;
  logic          skid_we;
  logic          load;
  logic [AW-1:0] ld_pc;
  logic [DW-1:0] ld_inst;

  assign redir   = trap_valid | br_valid | jmp_valid;
  assign flush   = redir;
  assign im_req  = (state == REQ);
  assign im_addr = pc;
  assign pc4     = pc + AW'(4);

  always_comb begin
    tgt = jmp_target;
    priority case (1'b1)
      trap_valid: tgt = trap_target;
      br_valid:   tgt = br_target;
      default:    tgt = jmp_target;
    endcase
    tgt[1:0] = 2'b00;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    skid_we = 1'b0;
    load    = 1'b0;
    ld_pc   = pc;
    ld_inst = im_rdata;
    unique case (state)
      IDLE: begin
        state_n = REQ;
        if (redir) pc_n = tgt;
      end
      REQ: begin
        if (redir) pc_n = tgt;
        if (im_gnt) state_n = redir ? DROP : RESP;
      end
      RESP: begin
        if (redir) begin
          pc_n    = tgt;
          state_n = im_rvalid ? REQ : DROP;
        end else if (im_rvalid) begin
          if (!if_valid || !hazard_stall) begin
            load    = 1'b1;
            pc_n    = pc4;
            state_n = REQ;
          end else begin
            skid_we = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_n    = tgt;
          state_n = REQ;
        end else if (!hazard_stall) begin
          load    = 1'b1;
          ld_pc   = skid_pc;
          ld_inst = skid_inst;
          pc_n    = pc4;
          state_n = REQ;
        end
      end
      DROP: begin
        if (redir) pc_n = tgt;
        if (im_rvalid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_VEC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (skid_we) begin
      skid_pc   <= pc;
      skid_inst <= im_rdata;
    end
  end

  // A redirect kills the presented instruction even under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else if (redir) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= ld_pc;
      if_inst  <= ld_inst;
    end else if (!hazard_stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule
